// File: rtl/uart_arb_pkg.sv
// Shared types and defaults for the UART transmit arbiter.
// The FSM state enum, parameter defaults and the grant-index width helper live here.
package uart_arb_pkg;

    localparam int NUM_REQ_DEF = 4;
    localparam int DW_DEF      = 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT_LOW,
        S_WAIT_HIGH
    } arb_state_t;

    // Keep the grant index at least one bit wide so a single-requester build still elaborates.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_arb_rr_pick.sv
// Round-robin search: the lowest requesting index at or after ptr wins, wrapping to 0.
module rr_pick
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int GW      = idx_w(NUM_REQ_DEF)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [GW-1:0]      ptr,
    output logic [GW-1:0]      winner,
    output logic               valid
);

    always_comb begin
        int unsigned idx;
        idx    = 0;
        winner = '0;
        valid  = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!valid && ((req & (NUM_REQ'(1) << idx)) != '0)) begin
                winner = GW'(idx);
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter feeding one UART transmit engine, one byte in flight at a time.
// Define UART_ARB_LOCK_EN to keep a requester granted until it acks a byte flagged last.
//
// state       | meaning
// S_IDLE      | wait for txrdy and a request, register winner and its byte
// S_LOAD      | pulse load and ack[grant] on the next edge
// S_WAIT_LOW  | wait for the engine to drop txrdy (byte accepted)
// S_WAIT_HIGH | wait for txrdy to return, then advance the round-robin pointer
module uart_tx_arb
    import uart_arb_pkg::*;
#(
    parameter int  NUM_REQ = NUM_REQ_DEF,
    parameter int  DW      = DW_DEF,
    localparam int GW      = idx_w(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ*DW-1:0] data,
    input  logic [NUM_REQ-1:0]    last,
    output logic [NUM_REQ-1:0]    ack,
    input  logic                  txrdy,
    output logic [DW-1:0]         out_port,
    output logic                  load,
    output logic [GW-1:0]         grant,
    output logic                  busy
);

    arb_state_t    state;
    logic [GW-1:0] ptr;
    logic [GW-1:0] winner;
    logic [GW-1:0] pick;
    logic [GW-1:0] next_ptr;
    logic [DW-1:0] pick_byte;
    logic          valid;
    logic          take;

    rr_pick #(.NUM_REQ(NUM_REQ), .GW(GW)) u_pick (
        .req    (req),
        .ptr    (ptr),
        .winner (winner),
        .valid  (valid)
    );

`ifdef UART_ARB_LOCK_EN
    logic lock;
    logic hold;
    // A locked owner that still requests bypasses the round-robin search entirely.
    assign hold = lock && req[grant];
    assign pick = hold ? grant : winner;
    assign take = txrdy && (hold || valid);
`else
    logic unused_last;
    assign unused_last = ^last;
    assign pick        = winner;
    assign take        = txrdy && valid;
`endif

    assign pick_byte = DW'(data >> (int'(pick) * DW));
    assign next_ptr  = (int'(grant) == NUM_REQ - 1) ? '0 : grant + GW'(1);
    assign busy      = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            out_port <= '0;
            load     <= 1'b0;
            ack      <= '0;
            grant    <= '0;
            ptr      <= '0;
`ifdef UART_ARB_LOCK_EN
            lock     <= 1'b0;
`endif
        end else begin
            load <= 1'b0;
            ack  <= '0;
            unique case (state)
                S_IDLE: begin
`ifdef UART_ARB_LOCK_EN
                    if (lock && !req[grant]) lock <= 1'b0;
`endif
                    if (take) begin
                        grant    <= pick;
                        out_port <= pick_byte;
                        state    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    load  <= 1'b1;
                    ack   <= NUM_REQ'(1) << grant;
`ifdef UART_ARB_LOCK_EN
                    lock  <= !last[grant];
`endif
                    state <= S_WAIT_LOW;
                end
                S_WAIT_LOW: begin
                    if (!txrdy) state <= S_WAIT_HIGH;
                end
                S_WAIT_HIGH: begin
                    if (txrdy) begin
                        state <= S_IDLE;
`ifdef UART_ARB_LOCK_EN
                        if (!lock) ptr <= next_ptr;
`else
                        ptr <= next_ptr;
`endif
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, the number of requesters sharing one UART transmit engine.
REQ-002 The block SHALL have parameter DW, default 8, the width of the byte presented to the transmit engine load port.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 req  input  NUM_REQ  per-requester byte-pending request; held high until the matching ack.
REQ-006 data  input  NUM_REQ*DW  per-requester byte; slice i belongs to requester i; stable while req[i] is high.
REQ-007 last  input  NUM_REQ  per-requester end-of-packet flag qualifying the current byte; used only under UART_ARB_LOCK_EN.
REQ-008 ack  output  NUM_REQ  one-cycle pulse; the requester's byte was handed to the transmit engine.
REQ-009 txrdy  input  1  transmit-engine ready status; high when idle.
REQ-010 out_port  output  DW  registered byte driven to the transmit engine data input.
REQ-011 load  output  1  one-cycle load strobe to the transmit engine.
REQ-012 grant  output  clog2(NUM_REQ)  index of the current or most recent owner.
REQ-013 busy  output  1  high in every state other than IDLE.

Function
REQ-014 The FSM SHALL have the states IDLE, LOAD, WAIT_LOW and WAIT_HIGH.
REQ-015 IDLE: when txrdy=1 and |req, the block SHALL register the winner into grant and data[winner] into out_port, then go to LOAD; otherwise it SHALL stay in IDLE.
REQ-016 Arbitration SHALL be round-robin: search starts at ptr and wraps from NUM_REQ-1 to 0; the lowest index at or after ptr wins.
REQ-017 LOAD: load=1 and ack[grant]=1 for exactly one cycle, then WAIT_LOW.
REQ-018 WAIT_LOW: the FSM SHALL wait for txrdy=0, then go to WAIT_HIGH.
REQ-019 WAIT_HIGH: the FSM SHALL wait for txrdy=1, then go to IDLE and set ptr=(grant+1) mod NUM_REQ.
REQ-020 Latency SHALL be 2 cycles from req sampled in IDLE (txrdy=1) to the load pulse; at most one byte is in flight.
REQ-021 If req[grant] drops after it is sampled and before ack, the registered byte SHALL still be sent and ack still pulsed.
REQ-022 If txrdy=0 in IDLE, no grant SHALL be issued; requests SHALL be held pending without loss.
REQ-023 Requests arriving during LOAD, WAIT_LOW or WAIT_HIGH SHALL be arbitrated only on return to IDLE.
REQ-024 ack, load and busy SHALL be mutually consistent: ack is one-hot or zero, and load=|ack.

Reset
REQ-025 While rst=0: state=IDLE, out_port=0, load=0, ack=0, grant=0, busy=0, ptr=0, lock cleared.
REQ-026 A reset during WAIT_LOW or WAIT_HIGH SHALL abandon the transfer; the in-flight byte is not re-acked.

Configuration
REQ-027 Macro UART_ARB_LOCK_EN, when defined, adds packet lock to arbitration.
- When a byte is acked with last[grant]=0, the lock is set.
- While locked, IDLE grants only requester grant, ptr is not advanced, and other requesters wait.
- The lock clears on an acked byte with last=1, or when req[grant]=0 in IDLE.
REQ-028 Without UART_ARB_LOCK_EN, last SHALL be ignored and every byte SHALL be arbitrated independently.

Structure
REQ-029 Package uart_arb_pkg SHALL hold the FSM state enum, the NUM_REQ/DW defaults and the grant-index width function.
REQ-030 A combinational sub-module rr_pick(req, ptr -> winner, valid) SHALL implement the round-robin search.

Verification
REQ-031 req=4'b0001, data0=8'hA5, txrdy=1 -> load high at cycle 2, out_port=8'hA5, ack=4'b0001.
REQ-032 req=4'b1111 held and the engine model drops txrdy for 10 cycles per byte -> grant order 0,1,2,3,0; no byte lost or duplicated.
REQ-033 req[2] high with txrdy=0 for 20 cycles -> no load; when txrdy rises, load within 2 cycles.
REQ-034 rst pulsed low during WAIT_HIGH -> all outputs 0 and state IDLE within the same cycle; the next request is served from ptr=0.
REQ-035 UART_ARB_LOCK_EN defined, req1 sends 3 bytes (last=0,0,1) while req0 and req3 are pending -> the three req1 bytes go back to back, then req3, then req0.
REQ-036 req0 dropped during LOAD -> byte still loaded and ack[0] pulsed; no second grant to requester 0.
